// File: rtl/ff_pipe.sv
// ff_pipe: DEPTH-stage valid/ready register slice with bubble collapse and occupancy count.
// Optional synchronous flush (flush_i port) is compiled in when FF_PIPE_FLUSH_EN is defined.
module ff_pipe #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 2,
  parameter bit               RESET_DATA = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
`ifdef FF_PIPE_FLUSH_EN
  input  logic                       flush_i,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_q, count_d;
  logic             flush;

`ifdef FF_PIPE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Handshake: a beat moves across a boundary only in a cycle where valid and
  // ready are both 1; valid never depends on ready, ready may depend on out_ready_i.
  // Stage k is ready when any stage at or after k is empty, or the sink takes a beat.
  always_comb begin
    logic hole;
    hole = 1'b0;
    rdy  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole   = hole | ~v_q[k];
      rdy[k] = hole | out_ready_i;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = in_valid_i;
      d_d[0] = in_data_i;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    // Flush drops every valid bit but leaves the data registers as they were.
    if (flush) begin
      v_d = '0;
      d_d = d_q;
    end
  end

  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  generate
    if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (reset) d_q[k] <= RESET_VAL;
          else       d_q[k] <= d_d[k];
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          d_q[k] <= d_d[k];
        end
      end
    end
  endgenerate

  // Reset wins over flush and masks the output side so no beat leaves during it.
  assign in_ready_o  = reset | (rdy[0] & ~flush);
  assign out_valid_o = v_q[DEPTH-1] & ~flush & ~reset;
  assign out_data_o  = d_q[DEPTH-1];
  assign count_o     = count_q;

endmodule

// File: tb/tb_ff_pipe.sv
// tb_ff_pipe: randomized and directed checks of ff_pipe (DEPTH=3, RESET_VAL=8'hA5)
// against a queue-based reference model of in-flight beats and their accept times.
module tb_ff_pipe;
  localparam int DEPTH = 3;
  localparam int W     = 8;

  logic         clk;
  logic         reset;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;
  logic         flush_s;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  ff_pipe #(
    .WIDTH(W), .DEPTH(DEPTH), .RESET_DATA(1'b1), .RESET_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
`ifdef FF_PIPE_FLUSH_EN
    .flush_i(flush_s),
`endif
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle, compare at the falling edge, then advance the model over the rising edge.
  // The oldest beat never waits behind anything, so it reaches the output DEPTH-1 edges after acceptance.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic fl, input logic rs, output logic accepted);
    logic exp_v, exp_r, inf, outf;
    in_valid_i = iv; in_data_i = id; out_ready_i = ordy; flush_s = fl; reset = rs;
    inf = 1'b0; outf = 1'b0;
    @(negedge clk);
    if (rs) begin
      check("rst_ready", in_ready_o, 1);
    end else if (fl) begin
      check("flush_ready", in_ready_o, 0);
      check("flush_valid", out_valid_o, 0);
    end else begin
      exp_v = 1'b0;
      if (exp_q.size() > 0) exp_v = (cyc >= acc_q[0] + DEPTH - 1);
      exp_r = (exp_q.size() < DEPTH) || ordy;
      check("valid", out_valid_o, exp_v);
      check("ready", in_ready_o, exp_r);
      check("count", count_o, exp_q.size());
      if (exp_v) check("data", out_data_o, exp_q[0]);
      inf  = iv && exp_r;
      outf = exp_v && ordy;
      if (outf) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (inf) begin
        exp_q.push_back(id);
        acc_q.push_back(cyc + 1);
      end
    end
    accepted = inf;
    @(posedge clk);
    cyc++;
    if (rs || fl) begin
      exp_q.delete();
      acc_q.delete();
    end
    #1;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic a;
    logic [W-1:0] nxt;
    flush_s = 1'b0;

    // Reset with all data registers at RESET_VAL.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, a);
    check("rst_data", out_data_o, 8'hA5);
    check("rst_count", count_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);

    // Full-rate stream 0x01..0x10.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0, a);
    drain();

    // Stall: offer 5 beats into a blocked pipe, then release for one cycle.
    nxt = 8'h20;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, nxt, 1'b0, 1'b0, 1'b0, a);
      if (a) nxt++;
    end
    check("stall_accepted", nxt, 8'h23);
    step(1'b1, nxt, 1'b1, 1'b0, 1'b0, a);
    if (a) nxt++;
    for (int i = 0; i < 3; i++) step(1'b1, nxt, 1'b0, 1'b0, 1'b0, a);
    drain();

    // Randomized traffic with varying stall bias.
    for (int i = 0; i < 10000; i++) begin
      int bias;
      bias = (i / 1000) % 4;
      step(($urandom_range(0, 3) >= bias[1:0]) ? 1'b1 : 1'b0, W'($urandom),
           ($urandom_range(0, 3) >= 2'(3 - bias)) ? 1'b1 : 1'b0, 1'b0, 1'b0, a);
    end
    drain();

    // Reset in mid-flight with count at 2 and both handshakes active.
    step(1'b1, 8'h51, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, a);
    check("pre_rst_count", count_o, 2);
    step(1'b1, 8'h53, 1'b1, 1'b0, 1'b1, a);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_valid", out_valid_o, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);

`ifdef FF_PIPE_FLUSH_EN
    // Fill, flush with both sides active, then accept on the next cycle.
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b0, a);
    check("pre_flush_count", count_o, 3);
    step(1'b1, 8'h70, 1'b1, 1'b1, 1'b0, a);
    check("flush_count", count_o, 0);
    step(1'b1, 8'h71, 1'b1, 1'b0, 1'b0, a);
    check("post_flush_accept", a, 1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
